// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package instr_loader_pkg;

  localparam int DEPTH_DEF  = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int LANES      = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/instr_loader_byte_packer.sv
// byte_packer: gathers bytes little-endian into a 32-bit word.
// The word output already contains the byte being strobed this cycle, so the
// parent can register the complete word on the same edge as the 4th byte.
module byte_packer
  import instr_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        strobe,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        complete
);

  logic [1:0]  lane;
  logic [31:0] acc;

  // Merge the incoming byte into its lane of the stored partial word.
  always_comb begin
    word = acc;
    word[{lane, 3'b000} +: 8] = data;
  end

  assign complete = strobe && (lane == 2'(LANES - 1));

  // Lane counter and accumulator; a finished word leaves the accumulator empty.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lane <= 2'd0;
      acc  <= 32'd0;
    end else if (strobe) begin
      lane <= lane + 2'd1;
      acc  <= complete ? 32'd0 : word;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// instr_loader: streams bytes into the instruction memory and holds the core
// in reset until the requested number of words has been written.
// Optional feature macro: INSTR_LOADER_CHECKSUM_EN (adds CHECK state and err).
// Handshake: a byte transfers on a rising edge where in_valid && in_ready;
// in_ready is registered and only high in LOAD/CHECK. w_en has no handshake.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              w_en,
  output logic [31:0]       w_addr,
  output logic [31:0]       w_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  state_t          state;
  logic [ADDR_W:0] target;
  logic [ADDR_W:0] word_cnt;
  logic [ADDR_W:0] word_cnt_inc;
  logic [ADDR_W:0] tgt_next;
  logic            clear;
  logic            strobe;
  logic            complete;
  logic [31:0]     word;

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [31:0] sum;
  logic        err_r;
  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  assign tgt_next     = (word_count > DEPTH_W) ? DEPTH_W : word_count;
  assign word_cnt_inc = word_cnt + (ADDR_W + 1)'(1);
  assign clear        = start && (state == ST_IDLE || state == ST_DONE);
  assign strobe       = in_valid && in_ready;

  byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .strobe   (strobe),
    .data     (in_data),
    .word     (word),
    .complete (complete)
  );

  // Load FSM with registered handshake, write-port and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      in_ready <= 1'b0;
      w_en     <= 1'b0;
      w_addr   <= 32'd0;
      w_data   <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cpu_hold <= 1'b1;
      target   <= '0;
      word_cnt <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      sum      <= 32'd0;
      err_r    <= 1'b0;
`endif
    end else begin
      w_en <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            target   <= tgt_next;
            word_cnt <= '0;
            done     <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum      <= 32'd0;
            err_r    <= 1'b0;
`endif
            if (tgt_next == '0) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              cpu_hold <= 1'b0;
              in_ready <= 1'b0;
            end else begin
              state    <= ST_LOAD;
              busy     <= 1'b1;
              cpu_hold <= 1'b1;
              in_ready <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (complete) begin
            w_en     <= 1'b1;
            w_data   <= word;
            w_addr   <= {{(32 - ADDR_W){1'b0}}, word_cnt[ADDR_W-1:0]};
            word_cnt <= word_cnt_inc;
`ifdef INSTR_LOADER_CHECKSUM_EN
            sum      <= sum + word;
            if (word_cnt_inc == target) begin
              state <= ST_CHECK;
            end
`else
            if (word_cnt_inc == target) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              cpu_hold <= 1'b0;
              in_ready <= 1'b0;
            end
`endif
          end
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (complete) begin
            state    <= ST_DONE;
            err_r    <= (word != sum);
            done     <= 1'b1;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
            in_ready <= 1'b0;
          end
        end
`endif
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          cpu_hold <= 1'b1;
        end
      endcase
    end
  end

endmodule
